// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit
// ----------------------------------------------------------------------------
// Instruction fetch stage of the 4-stage 16-bit pipeline (producer side of
// the IF/ID interface). Owns the PC, issues single-word reads to instruction
// memory with a req/ack handshake (at most one request outstanding, in-order
// rvalid responses), buffers returned words together with their PC in a
// 2-entry FIFO and presents the FIFO head to decode with valid/ready.
// Branch redirects flush the FIFO and drop any response still in flight.
//
// Parameters:
//   RESET_PC        PC loaded on reset
//   PC_INC          PC increment per fetch (word-addressed memory)
//
// Ports:
//   clk             in   1   clock, all state updates on posedge
//   reset_n         in   1   asynchronous active-low reset
//   imem_req        out  1   fetch request valid
//   imem_addr       out  16  fetch address (current PC)
//   imem_ack        in   1   request accepted (imem_req & imem_ack = issue)
//   imem_rvalid     in   1   read data valid (in order, >=1 cycle after issue)
//   imem_rdata      in   16  instruction word
//   redirect_valid  in   1   taken branch/jump: flush and refetch
//   redirect_pc     in   16  new PC
//   inst_valid      out  1   FIFO head valid toward decode
//   inst_out        out  16  FIFO head instruction
//   pc_out          out  16  PC of FIFO head instruction
//   inst_ready      in   1   decode accepts head (inst_valid & inst_ready = pop)
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    output logic [15:0] inst_out,
    output logic [15:0] pc_out,
    input  logic        inst_ready
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // may issue a request
        ST_WAIT  = 2'd1,   // request outstanding, response will be kept
        ST_DROP  = 2'd2    // request outstanding, response will be discarded
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Cleared by reset, set on the first clock edge after release; keeps
    // imem_req low until that edge even though the FSM resets into ST_FETCH.
    logic        r_run;

    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] r_req_pc;
    logic [15:0] w_req_pc_nxt;

    // 2-entry FIFO of {instruction, pc}
    logic [15:0] r_fifo_inst [2];
    logic [15:0] r_fifo_pc   [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_issue;
    logic        w_push;
    logic        w_pop;
    logic        w_flush;

    // ------------------------------------------------------------------------
    // Memory request side
    // ------------------------------------------------------------------------
    // Credit rule: a request is only issued when a FIFO slot is free, so the
    // response always has somewhere to go even if decode stalls meanwhile.
    assign imem_req  = r_run && (r_state == ST_FETCH) && (r_count != 2'd2);
    assign imem_addr = r_pc;
    assign w_issue   = imem_req && imem_ack;

    // ------------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------------
    // A redirect flushes the FIFO; a pop in the same cycle is meaningless and
    // is suppressed so the pointers simply restart from zero.
    assign w_flush    = redirect_valid;
    assign w_pop      = inst_valid && inst_ready && !redirect_valid;
    assign inst_valid = (r_count != 2'd0);
    assign inst_out   = r_fifo_inst[r_rd_ptr];
    assign pc_out     = r_fifo_pc[r_rd_ptr];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_FETCH;
            r_run    <= 1'b0;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            r_state  <= w_state_nxt;
            r_run    <= 1'b1;
            r_pc     <= w_pc_nxt;
            r_req_pc <= w_req_pc_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state, PC and push decision
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_req_pc_nxt = r_req_pc;
        w_push       = 1'b0;

        case (r_state)
            ST_FETCH: begin
                // rvalid here has no matching request and is ignored
                if (w_issue) begin
                    w_state_nxt  = ST_WAIT;
                    w_pc_nxt     = r_pc + PC_INC;
                    w_req_pc_nxt = r_pc;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase

        // Redirect overrides everything above. The outstanding (or just
        // issued) request belongs to the old path: if its response has not
        // arrived by this edge we must sit in DROP until it does.
        if (redirect_valid) begin
            w_push   = 1'b0;
            w_pc_nxt = redirect_pc;
            if (r_state == ST_FETCH) begin
                w_state_nxt = w_issue ? ST_DROP : ST_FETCH;
            end else begin
                w_state_nxt = imem_rvalid ? ST_FETCH : ST_DROP;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage and occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo_inst[0] <= '0;
            r_fifo_inst[1] <= '0;
            r_fifo_pc[0]   <= '0;
            r_fifo_pc[1]   <= '0;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else if (w_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_inst[r_wr_ptr] <= imem_rdata;
                r_fifo_pc[r_wr_ptr]   <= r_req_pc;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit
// ----------------------------------------------------------------------------
// Bench for fetch_unit. Two instances share all inputs: one with the default
// reset PC and one with RESET_PC = 16'hFFFE for the wrap-around case; 'sel'
// picks which one the memory model and monitors observe.
// Memory model returns word {~addr[7:0], addr[7:0]} for address addr.
// Timing within a cycle: memory model drives at negedge+1, directed stimulus
// at negedge+2, monitors sample at negedge+3 (posedge is at negedge+5).
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_ready;

    logic        a_req, a_ival, b_req, b_ival;
    logic [15:0] a_addr, a_inst, a_pc, b_addr, b_inst, b_pc;

    logic        sel;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        inst_valid;
    logic [15:0] inst_out;
    logic [15:0] pc_out;

    assign imem_req   = sel ? b_req  : a_req;
    assign imem_addr  = sel ? b_addr : a_addr;
    assign inst_valid = sel ? b_ival : a_ival;
    assign inst_out   = sel ? b_inst : a_inst;
    assign pc_out     = sel ? b_pc   : a_pc;

    fetch_unit #(.RESET_PC(16'h0000), .PC_INC(16'd1)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (a_req),
        .imem_addr      (a_addr),
        .imem_ack       (imem_ack),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (a_ival),
        .inst_out       (a_inst),
        .pc_out         (a_pc),
        .inst_ready     (inst_ready)
    );

    fetch_unit #(.RESET_PC(16'hFFFE), .PC_INC(16'd1)) u_dut_wrap (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (b_req),
        .imem_addr      (b_addr),
        .imem_ack       (imem_ack),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (b_ival),
        .inst_out       (b_inst),
        .pc_out         (b_pc),
        .inst_ready     (inst_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] exp_addr_q [$];
    logic [31:0] exp_inst_q [$];   // {pc, instruction}
    int          pop_cyc    [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event, value %h (cycle %0d)", name, act, cyc);
    endtask

    // ------------------------------------------------------------------------
    // Memory model: acks while budget remains, answers after 'lat' cycles.
    // ------------------------------------------------------------------------
    int          lat          = 1;
    int          budget       = 0;
    int          cd           = 0;
    logic [15:0] paddr        = '0;
    bit          stale_inject = 1'b0;

    initial begin
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    end

    always @(negedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        if (!reset_n) cd = 0;
        if (stale_inject) begin
            imem_rvalid  = 1'b1;
            imem_rdata   = 16'hDEAD;
            stale_inject = 1'b0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = {~paddr[7:0], paddr[7:0]};
            end
        end
        imem_ack = (budget > 0);
        if (reset_n && imem_req && imem_ack) begin
            cd    = lat;
            paddr = imem_addr;
            budget--;
        end
    end

    // ------------------------------------------------------------------------
    // Monitors: issued addresses and instructions delivered to decode.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        logic [31:0] e;
        #3;
        if (reset_n && imem_req && imem_ack) begin
            if (exp_addr_q.size() == 0) unexpected("issue", {16'h0, imem_addr});
            else check("issue_addr", {16'h0, imem_addr}, {16'h0, exp_addr_q.pop_front()});
        end
        if (reset_n && inst_valid && inst_ready && !redirect_valid) begin
            pop_cyc.push_back(cyc);
            if (exp_inst_q.size() == 0) unexpected("pop", {pc_out, inst_out});
            else begin
                e = exp_inst_q.pop_front();
                check("pop_pc",   {16'h0, pc_out},   {16'h0, e[31:16]});
                check("pop_inst", {16'h0, inst_out}, {16'h0, e[15:0]});
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [15:0] rpc);
        tick();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        budget         = 0;
        #1;
        check("rst_req",   {31'h0, imem_req},   32'h0);
        check("rst_addr",  {16'h0, imem_addr},  {16'h0, rpc});
        check("rst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_inst",  {16'h0, inst_out},   32'h0);
        check("rst_pc",    {16'h0, pc_out},     32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("req_before_edge", {31'h0, imem_req}, 32'h0);
        exp_addr_q.delete();
        exp_inst_q.delete();
        pop_cyc.delete();
    endtask

    task automatic wait_issue(input int max);
        int i;
        i = 0;
        while (i < max && !(imem_req && imem_ack)) begin
            tick();
            i++;
        end
        if (!(imem_req && imem_ack)) unexpected("issue_timeout", 32'(max));
    endtask

    task automatic wait_drain(input int max);
        int i;
        i = 0;
        while (i < max && (exp_addr_q.size() != 0 || exp_inst_q.size() != 0)) begin
            tick();
            i++;
        end
        check("addr_q_drained", 32'(exp_addr_q.size()), 32'h0);
        check("inst_q_drained", 32'(exp_inst_q.size()), 32'h0);
        repeat (4) tick();
    endtask

    // ------------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------------
    initial begin
        sel            = 1'b0;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;

        // 1: straight-line fetch, 1-cycle memory, decode always ready
        do_reset(16'h0000);
        lat = 1; inst_ready = 1'b1;
        exp_addr_q = '{16'h0000, 16'h0001, 16'h0002};
        exp_inst_q = '{32'h0000_FF00, 32'h0001_FE01, 32'h0002_FD02};
        budget = 3;
        wait_drain(40);
        check("t1_pops", 32'(pop_cyc.size()), 32'd3);
        if (pop_cyc.size() == 3) begin
            check("t1_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
            check("t1_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
        end

        // 2: decode stalled; two words fill the FIFO, then drain in order
        do_reset(16'h0000);
        lat = 1; inst_ready = 1'b0;
        exp_addr_q = '{16'h0000, 16'h0001, 16'h0002};
        budget = 3;
        repeat (10) tick();
        check("t2_req_off",  {31'h0, imem_req},   32'h0);
        check("t2_addr_left", 32'(exp_addr_q.size()), 32'd1);
        check("t2_valid",    {31'h0, inst_valid}, 32'h1);
        check("t2_head_pc",  {16'h0, pc_out},     32'h0000);
        check("t2_head_ins", {16'h0, inst_out},   32'hFF00);
        repeat (3) tick();
        check("t2_hold_pc",  {16'h0, pc_out},     32'h0000);
        check("t2_hold_ins", {16'h0, inst_out},   32'hFF00);
        exp_inst_q = '{32'h0000_FF00, 32'h0001_FE01, 32'h0002_FD02};
        inst_ready = 1'b1;
        wait_drain(40);

        // 3: redirect to 0040 while waiting on a 3-cycle response
        do_reset(16'h0000);
        lat = 3; inst_ready = 1'b1;
        exp_addr_q = '{16'h0000};
        budget = 1;
        wait_issue(10);
        tick();
        check("t3_waiting", {31'h0, imem_req}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        exp_addr_q.push_back(16'h0040);
        exp_inst_q.push_back(32'h0040_BF40);
        budget = 1;
        tick();
        redirect_valid = 1'b0;
        check("t3_flushed", {31'h0, inst_valid}, 32'h0);
        wait_drain(40);

        // 4: redirect to 0080 coinciding with issue of 0005 and pop of 0004
        do_reset(16'h0000);
        lat = 1; inst_ready = 1'b1;
        exp_addr_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        exp_inst_q = '{32'h0000_FF00, 32'h0001_FE01, 32'h0002_FD02, 32'h0003_FC03};
        budget = 6;
        begin
            int i;
            i = 0;
            while (i < 40 && !(imem_req && imem_ack && imem_addr == 16'h0005)) begin
                tick();
                i++;
            end
        end
        check("t4_issue5",  {31'h0, (imem_req && imem_ack)}, 32'h1);
        check("t4_addr5",   {16'h0, imem_addr},  32'h0005);
        check("t4_popping", {31'h0, inst_valid}, 32'h1);
        check("t4_pop_pc",  {16'h0, pc_out},     32'h0004);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0080;
        exp_addr_q.push_back(16'h0080);
        exp_inst_q.push_back(32'h0080_7F80);
        tick();
        redirect_valid = 1'b0;
        budget = 1;
        check("t4_flushed", {31'h0, inst_valid}, 32'h0);
        wait_drain(40);

        // 5: PC wraps from FFFF to 0000
        sel = 1'b1;
        do_reset(16'hFFFE);
        lat = 1; inst_ready = 1'b1;
        exp_addr_q = '{16'hFFFE, 16'hFFFF, 16'h0000};
        exp_inst_q = '{32'hFFFE_01FE, 32'hFFFF_00FF, 32'h0000_FF00};
        budget = 3;
        wait_drain(40);
        sel = 1'b0;

        // 6: reset in the middle of a long fetch with a word queued
        do_reset(16'h0000);
        lat = 1; inst_ready = 1'b0;
        exp_addr_q = '{16'h0000};
        budget = 1;
        begin
            int i;
            i = 0;
            while (i < 10 && !inst_valid) begin
                tick();
                i++;
            end
        end
        check("t6_queued", {31'h0, inst_valid}, 32'h1);
        lat = 5;
        exp_addr_q.push_back(16'h0001);
        budget = 1;
        wait_issue(10);
        tick();
        check("t6_waiting", {31'h0, imem_req}, 32'h0);
        reset_n = 1'b0;
        #1;
        check("t6_rst_req",   {31'h0, imem_req},   32'h0);
        check("t6_rst_addr",  {16'h0, imem_addr},  32'h0000);
        check("t6_rst_valid", {31'h0, inst_valid}, 32'h0);
        check("t6_rst_inst",  {16'h0, inst_out},   32'h0);
        check("t6_rst_pc",    {16'h0, pc_out},     32'h0);
        tick();
        // late response from the aborted fetch lands on the first edge after release
        stale_inject = 1'b1;
        lat = 1; inst_ready = 1'b1;
        exp_addr_q.delete();
        exp_inst_q.delete();
        exp_addr_q.push_back(16'h0000);
        exp_inst_q.push_back(32'h0000_FF00);
        budget = 1;
        tick();
        check("t6_stale_seen", {31'h0, imem_rvalid}, 32'h1);
        reset_n = 1'b1;
        #1;
        check("t6_req_before_edge", {31'h0, imem_req}, 32'h0);
        wait_drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
